// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_rsp_queue.sv
// Small in-order FIFO holding fetched instruction words until the buffer takes them.
module fetch_rsp_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst_n || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests from the PC, queues the
// responses and forwards them to the instruction buffer; redirects drop stale data.
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int                    INST_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data_in,
    input  logic                  buf_full,
    output logic                  flush_out,
    output logic [ADDR_WIDTH-1:0] fetch_pc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         w_outstanding_nxt;
    logic [CW-1:0]         w_rem;
    logic                  r_flush;

    logic [CW-1:0]         w_q_count;
    logic                  w_q_empty;
    logic                  w_q_full;
    logic                  w_q_push;
    logic                  w_q_pop;
    logic [CW:0]           w_inflight_total;
    logic                  w_req_fire;

    // Credits cover both words still in memory and words waiting in the queue.
    assign w_inflight_total = {1'b0, r_outstanding} + {1'b0, w_q_count};

    assign imem_req_valid = (r_state == FETCH) & ~stall & ~redirect_valid & ~rst_n
                          & (w_inflight_total < (CW + 1)'(MAX_OUTSTANDING));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_q_push     = imem_rsp_valid & (r_state == FETCH) & ~redirect_valid;
    assign buf_write_en = ~w_q_empty & ~buf_full & ~redirect_valid & ~rst_n;
    assign w_q_pop      = buf_write_en;

    assign flush_out = r_flush;
    assign fetch_pc  = r_pc;

    fetch_rsp_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (INST_WIDTH)
    ) u_rsp_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_q_push),
        .i_pop   (w_q_pop),
        .i_clear (redirect_valid),
        .i_data  (imem_rsp_data),
        .o_data  (buf_data_in),
        .o_count (w_q_count),
        .o_empty (w_q_empty),
        .o_full  (w_q_full)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_outstanding_nxt = r_outstanding;
        w_rem             = r_outstanding - CW'(imem_rsp_valid);

        if (w_req_fire && !imem_rsp_valid) begin
            w_outstanding_nxt = r_outstanding + 1'b1;
        end else if (!w_req_fire && imem_rsp_valid) begin
            w_outstanding_nxt = w_rem;
        end

        if (w_req_fire) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(PC_STEP);
        end

        if (redirect_valid) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = (w_rem == '0) ? FETCH : DRAIN;
        end else begin
            case (r_state)
                FETCH:   w_state_nxt = FETCH;
                DRAIN:   w_state_nxt = (w_outstanding_nxt == '0) ? FETCH : DRAIN;
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_flush       <= redirect_valid;
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst_n)
        imem_rsp_valid |-> (r_outstanding != '0));

    a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
        !(w_q_push && w_q_full && !w_q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model (in-flight list with
// stale tags plus a word queue) is compared against the DUT on every cycle.
module tb_fetch_unit;

    localparam int          IW   = 32;
    localparam int          AW   = 32;
    localparam int          MAXO = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          buf_write_en;
    logic [IW-1:0] buf_data_in;
    logic          buf_full = 1'b0;
    logic          flush_out;
    logic [AW-1:0] fetch_pc;

    fetch_unit #(
        .INST_WIDTH      (IW),
        .ADDR_WIDTH      (AW),
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .buf_write_en   (buf_write_en),
        .buf_data_in    (buf_data_in),
        .buf_full       (buf_full),
        .flush_out      (flush_out),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    // One entry per accepted request, oldest first; stale = issued before a redirect.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } flight_t;

    flight_t     fl[$];
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    bit          m_flush;
    int          cyc;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    // rsp_mode: 0 = memory holds responses, 1 = respond when due, 2 = respond randomly when due.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                        input bit full, input bit rdy, input int rsp_mode);
        bit      exp_rv;
        bit      exp_we;
        bit      any_stale;
        bit      rsp;
        bit      fire;
        flight_t f;
        @(posedge clk);
        #1;
        cyc++;
        rst_n          = 1'b0;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        buf_full       = full;
        imem_req_ready = rdy;
        rsp = (fl.size() > 0) && (fl[0].due <= cyc) &&
              ((rsp_mode == 1) || ((rsp_mode == 2) && ($urandom_range(0, 9) < 6)));
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(fl[0].addr) : $urandom();
        #1;

        any_stale = 1'b0;
        foreach (fl[i]) if (fl[i].stale) any_stale = 1'b1;
        exp_rv = !any_stale && !st && !rd && ((fl.size() + mq.size()) < MAXO);
        exp_we = (mq.size() > 0) && !full && !rd;

        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("buf_we", 32'(buf_write_en), 32'(exp_we));
        if (exp_we) check("buf_data", buf_data_in, mq[0]);
        check("flush", 32'(flush_out), 32'(m_flush));
        check("fetch_pc", fetch_pc, m_pc);

        fire = exp_rv && rdy;
        if (exp_we) void'(mq.pop_front());
        if (rsp) begin
            f = fl.pop_front();
            if (!f.stale && !rd) mq.push_back(mem_word(f.addr));
        end
        if (rd) begin
            mq.delete();
            foreach (fl[i]) fl[i].stale = 1'b1;
            m_pc = rpc;
        end
        if (fire) begin
            fl.push_back('{m_pc, cyc + 1, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        m_flush = rd;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst_n          = 1'b1;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            buf_full       = 1'b0;
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            #1;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_buf_we", 32'(buf_write_en), 32'd0);
        end
        fl.delete();
        mq.delete();
        m_pc    = RST_PC;
        m_flush = 1'b0;
    endtask

    // Let every outstanding response return and the queue empty into the buffer.
    task automatic settle();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    endtask

    initial begin
        logic [31:0] rpc;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_pc     = RST_PC;
        m_flush  = 1'b0;

        // Reset, then a streaming fetch with 1-cycle memory latency.
        do_reset(2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_first_valid", 32'(imem_req_valid), 32'd1);
        check("pin_first_addr", imem_req_addr, 32'h0000_0100);
        check("pin_reset_pc", fetch_pc, 32'h0000_0100);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            if (buf_write_en) break;
        end
        check("pin_first_we", 32'(buf_write_en), 32'd1);
        check("pin_first_word", buf_data_in, 32'hC0DE_0100);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Buffer full for 10 cycles, then released.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("pin_full_no_req", 32'(imem_req_valid), 32'd0);
        check("pin_full_no_we", 32'(buf_write_en), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Redirect with two requests in flight.
        settle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        check("pin_flush_pulse", 32'(flush_out), 32'd1);
        check("pin_drain_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            if (imem_req_valid) break;
        end
        check("pin_resume_valid", 32'(imem_req_valid), 32'd1);
        check("pin_resume_addr", imem_req_addr, 32'h0000_0400);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            if (buf_write_en) break;
        end
        check("pin_resume_word", buf_data_in, 32'hC0DE_0400);

        // Redirect in the same cycle as the only outstanding response.
        settle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_no_drain_valid", 32'(imem_req_valid), 32'd1);
        check("pin_no_drain_addr", imem_req_addr, 32'h0000_0400);

        // Stall mid-stream.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_stall_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);

        // PC wrap at the top of the address space.
        settle();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_wrap_top", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_wrap_zero", imem_req_addr, 32'h0000_0000);

        // Reset with one request in flight and one word queued.
        settle();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        do_reset(1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("pin_rst_pc", fetch_pc, 32'h0000_0100);
        check("pin_rst_flush", 32'(flush_out), 32'd0);
        check("pin_rst_no_we", 32'(buf_write_en), 32'd0);
        check("pin_rst_addr", imem_req_addr, 32'h0000_0100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom();
            rpc[1:0] = 2'b00;
            if (($urandom_range(0, 9) == 0)) rpc[31:8] = 24'hFFFFFF;
            if ((i % 700) == 699) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 9) < 2, $urandom_range(0, 49) < 2, rpc,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, 2);
            end
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
